// File: rtl/aes_gf_pkg.sv
// Shared GF(2^8) definitions for the sequenced MixColumns engine.
// The PRE state exists only when AES_INV_MIXCOL_EN is defined.
package aes_gf_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef logic [7:0] gf_byte_t;

`ifdef AES_INV_MIXCOL_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } mc_state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mc_state_t;
`endif

    function automatic gf_byte_t xtime(input gf_byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_mixcol_seq_if.sv
// Column handshake bundle for aes_mixcol_seq; in_inv exists only with AES_INV_MIXCOL_EN.
interface aes_mixcol_seq_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_col;
`ifdef AES_INV_MIXCOL_EN
    logic        in_inv;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_col;
    logic        busy;

    modport master (
        output in_valid,
        output in_col,
`ifdef AES_INV_MIXCOL_EN
        output in_inv,
`endif
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_col,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_col,
`ifdef AES_INV_MIXCOL_EN
        input  in_inv,
`endif
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_col,
        output busy
    );

endinterface

// File: rtl/aes_gf_xtime.sv
// Single combinational GF(2^8) multiply-by-2 unit, time-shared by the engine.
module aes_gf_xtime
    import aes_gf_pkg::*;
(
    input  gf_byte_t a,
    output gf_byte_t y
);

    assign y = xtime(a);

endmodule

// File: rtl/aes_mixcol_seq.sv
// Sequenced MixColumns over one shared xtime unit; 4 cycles forward, plus 4 PRE
// cycles for InvMixColumns when AES_INV_MIXCOL_EN is defined.
module aes_mixcol_seq
    import aes_gf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    aes_mixcol_seq_if.slave   bus
);

    mc_state_t   state_q, state_d;
    logic [1:0]  idx_q, idx_d, idx_nxt;
    gf_byte_t    s_q [4];
    gf_byte_t    s_d [4];
    gf_byte_t    r_q [4];
    gf_byte_t    r_d [4];
    gf_byte_t    t_q, t_d;
`ifdef AES_INV_MIXCOL_EN
    gf_byte_t    u_q, u_d;
    gf_byte_t    v_q, v_d;
`endif
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_col_q, out_col_d;
    logic        in_ready_q, in_ready_d;
    logic        busy_q, busy_d;
    gf_byte_t    xt_in, xt_out;

    aes_gf_xtime u_xtime (
        .a (xt_in),
        .y (xt_out)
    );

    assign idx_nxt = idx_q + 2'd1;

    // Next-state, datapath and handshake logic; every cycle uses at most one xtime.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        s_d         = s_q;
        r_d         = r_q;
        t_d         = t_q;
`ifdef AES_INV_MIXCOL_EN
        u_d         = u_q;
        v_d         = v_q;
`endif
        out_valid_d = out_valid_q;
        out_col_d   = out_col_q;
        xt_in       = 8'h00;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    s_d[0] = bus.in_col[31:24];
                    s_d[1] = bus.in_col[23:16];
                    s_d[2] = bus.in_col[15:8];
                    s_d[3] = bus.in_col[7:0];
                    t_d    = bus.in_col[31:24] ^ bus.in_col[23:16]
                           ^ bus.in_col[15:8]  ^ bus.in_col[7:0];
                    idx_d  = 2'd0;
`ifdef AES_INV_MIXCOL_EN
                    state_d = bus.in_inv ? PRE : CALC;
`else
                    state_d = CALC;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
`ifdef AES_INV_MIXCOL_EN
            // u = 4*(s0^s2), v = 4*(s1^s3); folding them in turns MixColumns into its inverse
            PRE: begin
                idx_d = idx_nxt;
                case (idx_q)
                    2'd0: begin
                        xt_in = s_q[0] ^ s_q[2];
                        u_d   = xt_out;
                    end
                    2'd1: begin
                        xt_in = u_q;
                        u_d   = xt_out;
                    end
                    2'd2: begin
                        xt_in = s_q[1] ^ s_q[3];
                        v_d   = xt_out;
                    end
                    default: begin
                        xt_in   = v_q;
                        v_d     = xt_out;
                        s_d[0]  = s_q[0] ^ u_q;
                        s_d[2]  = s_q[2] ^ u_q;
                        s_d[1]  = s_q[1] ^ xt_out;
                        s_d[3]  = s_q[3] ^ xt_out;
                        t_d     = s_d[0] ^ s_d[1] ^ s_d[2] ^ s_d[3];
                        state_d = CALC;
                    end
                endcase
            end
`endif
            CALC: begin
                xt_in      = s_q[idx_q] ^ s_q[idx_nxt];
                r_d[idx_q] = s_q[idx_q] ^ t_q ^ xt_out;
                idx_d      = idx_nxt;
                if (idx_q == 2'd3) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_col_d   = {r_d[0], r_d[1], r_d[2], r_d[3]};
                end else begin
                    state_d = CALC;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    // State and datapath registers; reset abandons any column in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            s_q         <= '{default: 8'h00};
            r_q         <= '{default: 8'h00};
            t_q         <= 8'h00;
`ifdef AES_INV_MIXCOL_EN
            u_q         <= 8'h00;
            v_q         <= 8'h00;
`endif
            out_valid_q <= 1'b0;
            out_col_q   <= 32'h0000_0000;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            s_q         <= s_d;
            r_q         <= r_d;
            t_q         <= t_d;
`ifdef AES_INV_MIXCOL_EN
            u_q         <= u_d;
            v_q         <= v_d;
`endif
            out_valid_q <= out_valid_d;
            out_col_q   <= out_col_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_col   = out_col_q;
    assign bus.busy      = busy_q;

endmodule
